// File: rtl/fxp_multiplier.sv
// ---------------------------------------------------------------------------
// fxp_multiplier
//   Sequential signed fixed-point multiplier using shift-add on operand
//   magnitudes. One multiplier bit is consumed per cycle, so every operation
//   takes N CALC cycles plus one SIGN cycle. The latency is fixed and does
//   not depend on the operand values.
//
//   Handshake: a one-cycle start pulse is sampled only in IDLE. The operands
//   are captured on that edge, so the caller may change them while busy.
//   busy is high from the cycle after start until done rises. done and
//   overflow then hold until the next accepted start. output_q holds until
//   the next SIGN state writes it.
//
//   Parameters:
//     N  total width in bits, 2's complement, including the sign bit
//     Q  number of fractional bits (shared by both operands and the result)
//
//   Ports:
//     clk           clock
//     rst_n         asynchronous active-low reset
//     start         one-cycle start pulse (ignored unless IDLE)
//     multiplicand  signed Q-format operand A
//     multiplier    signed Q-format operand B
//     busy          operation in progress
//     done          result valid
//     overflow      true product does not fit in N bits
//     output_q      signed Q-format product (magnitude truncated toward zero)
//
//   Build option:
//     FXP_MULT_SAT_EN  when defined, an overflowing result saturates to the
//                      largest positive or most negative value. When it is
//                      not defined, the low N bits of the signed result are
//                      returned. The overflow flag is the same in both builds.
// ---------------------------------------------------------------------------
module fxp_multiplier #(
    parameter int N = 22,
    parameter int Q = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] multiplicand,
    input  logic [N-1:0] multiplier,
    output logic         busy,
    output logic         done,
    output logic         overflow,
    output logic [N-1:0] output_q
);

    localparam int CW = $clog2(N);
    localparam int PW = 2 * N - Q;  // width of the product after dropping fraction bits

    // Magnitude limits of the integer-aligned product, P >> Q.
    localparam logic [PW-1:0] LIM_NEG = {{(N - Q){1'b0}}, 1'b1, {(N - 1){1'b0}}};
    localparam logic [PW-1:0] LIM_POS = LIM_NEG - PW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2
    } state_t;

    state_t          state;
    logic [N-1:0]    mag_a;
    logic [N-1:0]    mag_b;
    logic            neg;
    logic [2*N-1:0]  acc;
    logic [CW-1:0]   count;

    logic [N-1:0]    abs_a;
    logic [N-1:0]    abs_b;
    logic [2*N-1:0]  addend;
    logic [PW-1:0]   prod_int;
    logic [N-1:0]    mag_res;
    logic            ovf;
    logic [N-1:0]    signed_res;
    logic [N-1:0]    final_res;

    always_comb begin
        // An N-bit unsigned magnitude keeps -2^(N-1) exact.
        abs_a      = multiplicand[N-1] ? -multiplicand : multiplicand;
        abs_b      = multiplier[N-1]   ? -multiplier   : multiplier;
        addend     = {{N{1'b0}}, mag_a} << count;
        prod_int   = acc[2*N-1:Q];
        mag_res    = acc[N-1+Q:Q];
        // A negative result may reach -2^(N-1). A positive one stops at 2^(N-1)-1.
        ovf        = neg ? (prod_int > LIM_NEG) : (prod_int > LIM_POS);
        // Negating a zero magnitude gives zero, so there is no negative zero.
        signed_res = neg ? -mag_res : mag_res;
`ifdef FXP_MULT_SAT_EN
        if (ovf) begin
            final_res = neg ? {1'b1, {(N - 1){1'b0}}} : {1'b0, {(N - 1){1'b1}}};
        end else begin
            final_res = signed_res;
        end
`else
        final_res  = signed_res;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            mag_a    <= '0;
            mag_b    <= '0;
            neg      <= 1'b0;
            acc      <= '0;
            count    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
            output_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mag_a    <= abs_a;
                        mag_b    <= abs_b;
                        neg      <= multiplicand[N-1] ^ multiplier[N-1];
                        acc      <= '0;
                        count    <= '0;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        overflow <= 1'b0;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    if (mag_b[count]) begin
                        acc <= acc + addend;
                    end
                    count <= count + CW'(1);
                    if (count == CW'(N - 1)) begin
                        state <= SIGN;
                    end
                end
                SIGN: begin
                    output_q <= final_res;
                    overflow <= ovf;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fxp_multiplier.sv
// ---------------------------------------------------------------------------
// tb_fxp_multiplier
//   Bench for fxp_multiplier at N=22, Q=10. The driver issues directed
//   operations and pushes the hand-computed {overflow, output_q} into exp_q.
//   A monitor pops exp_q and compares each time done rises.
// ---------------------------------------------------------------------------
module tb_fxp_multiplier;

    localparam int N = 22;
    localparam int Q = 10;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [N-1:0] multiplicand;
    logic [N-1:0] multiplier;
    logic         busy;
    logic         done;
    logic         overflow;
    logic [N-1:0] output_q;

    int checks   = 0;
    int failures = 0;

    logic [N:0] exp_q[$];  // {overflow, output_q}
    logic       done_q = 1'b0;

    fxp_multiplier #(.N(N), .Q(Q)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .overflow     (overflow),
        .output_q     (output_q)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n && done && !done_q) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_done: got q=0x%0h ovf=%0b expected no result", output_q, overflow);
            end else begin
                logic [N:0] e;
                e = exp_q.pop_front();
                if (output_q !== e[N-1:0]) begin
                    failures++;
                    $display("FAIL result: got 0x%06h expected 0x%06h", output_q, e[N-1:0]);
                end
                checks++;
                if (overflow !== e[N]) begin
                    failures++;
                    $display("FAIL overflow: got %0b expected %0b", overflow, e[N]);
                end
            end
        end
        done_q = done;
    end

    // driver: entered and left at a negedge so consecutive calls are back-to-back
    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] exp_res, input logic exp_ovf,
                         input bit pulse_ignored);
        int lat;
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        exp_q.push_back({exp_ovf, exp_res});
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        check("done_drops_after_start", 32'(done), 32'd0);
        lat = 0;
        // the caller may scramble the operands while busy
        multiplicand = $urandom_range(0, (1 << N) - 1);
        multiplier   = $urandom_range(0, (1 << N) - 1);
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
            start = pulse_ignored && (lat == 5 || lat == 10);
            if (start) begin
                multiplicand = 22'h000400;
                multiplier   = 22'h000400;
            end
        end
        start = 1'b0;
        check("latency", 32'(lat), 32'd23);
        check("busy_clear_at_done", 32'(busy), 32'd0);
    endtask

    task automatic reset_abort();
        multiplicand = 22'h000600;
        multiplier   = 22'h000800;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_overflow", 32'(overflow), 32'd0);
        check("abort_output_q", 32'(output_q), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic [N-1:0] ovf_pos_res;
        logic [N-1:0] ovf_neg_res;
`ifdef FXP_MULT_SAT_EN
        ovf_pos_res = 22'h1FFFFF;
        ovf_neg_res = 22'h200000;
`else
        ovf_pos_res = 22'h3E8000;
        ovf_neg_res = 22'h018000;
`endif
        rst_n        = 1'b0;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);
        check("reset_output_q", 32'(output_q), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(22'h000600, 22'h000800, 22'h000C00, 1'b0, 1'b0); // 1.5 * 2.0
        do_op(22'h3FFA00, 22'h000800, 22'h3FF400, 1'b0, 1'b0); // -1.5 * 2.0
        do_op(22'h3FFA00, 22'h3FF800, 22'h000C00, 1'b0, 1'b0); // -1.5 * -2.0
        do_op(22'h0FA000, 22'h001000, ovf_pos_res, 1'b1, 1'b0); // 1000 * 4
        do_op(22'h306000, 22'h001000, ovf_neg_res, 1'b1, 1'b0); // -1000 * 4
        do_op(22'h200000, 22'h000400, 22'h200000, 1'b0, 1'b0); // -2048 * 1
        do_op(22'h000001, 22'h000001, 22'h000000, 1'b0, 1'b0); // 1 LSB * 1 LSB
        do_op(22'h3FFFFF, 22'h000001, 22'h000000, 1'b0, 1'b0); // -1 LSB * 1 LSB
        do_op(22'h000003, 22'h000200, 22'h000001, 1'b0, 1'b0); // 3 LSB * 0.5
        do_op(22'h3FFFFD, 22'h000200, 22'h3FFFFF, 1'b0, 1'b0); // -3 LSB * 0.5
        do_op(22'h000D00, 22'h3FFE00, 22'h3FF980, 1'b0, 1'b0); // 3.25 * -0.5
        do_op(22'h000000, 22'h3FFA00, 22'h000000, 1'b0, 1'b0); // 0 * -1.5
        do_op(22'h000600, 22'h000800, 22'h000C00, 1'b0, 1'b1); // starts while busy ignored

        reset_abort();
        do_op(22'h3FFA00, 22'h000800, 22'h3FF400, 1'b0, 1'b0); // works after abort

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
